// File: rtl/ccc_pkg.sv
// Shared widths and helpers for the fabric-clock
// enable generator.
package ccc_pkg;

  localparam int DEF_DIV_W = 16;
  localparam int DEF_LOCK_CYCLES = 16;

  typedef logic [DEF_DIV_W-1:0] div_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int sel_w(input int ch);
    int r;
    r = clog2(ch);
    return (r < 1) ? 1 : r;
  endfunction

  // Saturating stability counter must hold LOCK_CYCLES itself
  function automatic int lock_w(input int cyc);
    int r;
    r = clog2(cyc + 1);
    return (r < 1) ? 1 : r;
  endfunction

  localparam int DEF_LOCK_W = lock_w(DEF_LOCK_CYCLES);

endpackage

// File: rtl/ccc_clk_enable_gen_if.sv
// Control and status bundle between the enable
// generator and its fabric-side user.
interface ccc_clk_enable_gen_if
  import ccc_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DIV_W = DEF_DIV_W
) ();

  localparam int SEL_W = sel_w(CHANNELS);

  logic [CHANNELS-1:0] CH_EN;
  logic                DIV_WR;
  logic [SEL_W-1:0]    DIV_SEL;
  logic [DIV_W-1:0]    DIV_DATA;
  logic                SYNC;
  logic [CHANNELS-1:0] CE_OUT;
  logic [CHANNELS-1:0] TOG_OUT;
  logic [CHANNELS-1:0] PENDING;
  logic                LOCK;

  modport master (
    output CH_EN,
    output DIV_WR,
    output DIV_SEL,
    output DIV_DATA,
    output SYNC,
    input  CE_OUT,
    input  TOG_OUT,
    input  PENDING,
    input  LOCK
  );

  modport slave (
    input  CH_EN,
    input  DIV_WR,
    input  DIV_SEL,
    input  DIV_DATA,
    input  SYNC,
    output CE_OUT,
    output TOG_OUT,
    output PENDING,
    output LOCK
  );

endinterface

// File: rtl/ccc_ce_channel.sv
// One divider channel: counter, active/shadow
// divisor, pending flag, CE pulse and toggle.
module ccc_ce_channel
  import ccc_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int DEFAULT_DIV = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] data,
  output logic             ce,
  output logic             tog,
  output logic             pending
);

  localparam logic [DIV_W-1:0] RST_DIV =
    DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] act_q;
  logic [DIV_W-1:0] act_d;
  logic [DIV_W-1:0] shd_q;
  logic [DIV_W-1:0] shd_d;
  logic [DIV_W-1:0] last;
  logic             ce_q;
  logic             ce_d;
  logic             tog_q;
  logic             tog_d;
  logic             pend_q;
  logic             pend_d;
  logic             run;
  logic             tc;

  // A stored divisor of 0 counts as 1
  assign last = (act_q == '0) ? '0
              : act_q - DIV_W'(1);
  assign tc   = (cnt_q == last);
  assign run  = en & ~sync;

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    shd_d  = shd_q;
    ce_d   = 1'b0;
    tog_d  = tog_q;
    pend_d = pend_q;
    unique case (1'b1)
      sync: begin
        cnt_d  = '0;
        tog_d  = 1'b0;
        if (pend_q) act_d = shd_q;
        pend_d = 1'b0;
      end
      (!sync && !en): begin
        cnt_d  = '0;
        if (pend_q) act_d = shd_q;
        pend_d = 1'b0;
      end
      (run && tc): begin
        cnt_d  = '0;
        ce_d   = 1'b1;
        tog_d  = ~tog_q;
        if (pend_q) act_d = shd_q;
        pend_d = 1'b0;
      end
      (run && !tc): begin
        cnt_d  = cnt_q + DIV_W'(1);
      end
      default: begin
        cnt_d  = cnt_q;
      end
    endcase
    // A same-edge write is captured after any transfer
    if (wr) begin
      shd_d  = data;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      act_q  <= RST_DIV;
      shd_q  <= RST_DIV;
      ce_q   <= 1'b0;
      tog_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      ce_q   <= ce_d;
      tog_q  <= tog_d;
      pend_q <= pend_d;
    end
  end

  assign ce      = ce_q;
  assign tog     = tog_q;
  assign pending = pend_q;

endmodule

// File: rtl/ccc_clk_enable_gen.sv
// Top: write decode, SYNC fan-out and the LOCK
// stability counter over CHANNELS dividers.
module ccc_clk_enable_gen
  import ccc_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DIV_W = DEF_DIV_W,
  parameter int DEFAULT_DIV = 100,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input logic FAB_CLK,
  input logic M2F_RESET_N,
  ccc_clk_enable_gen_if.slave bus
);

  localparam int SEL_W  = sel_w(CHANNELS);
  localparam int LOCK_W = lock_w(LOCK_CYCLES);
  localparam logic [LOCK_W-1:0] LOCK_MAX =
    LOCK_W'(LOCK_CYCLES);

  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] ce_v;
  logic [CHANNELS-1:0] tog_v;
  logic [CHANNELS-1:0] pend_v;
  logic [LOCK_W-1:0]   stab_q;
  logic [LOCK_W-1:0]   stab_d;
  logic                lock_q;
  logic                lock_d;
  logic                clr;

  // Selects beyond CHANNELS match no channel
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = bus.DIV_WR &&
        (bus.DIV_SEL == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    ccc_ce_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (FAB_CLK),
      .rst_n   (M2F_RESET_N),
      .en      (bus.CH_EN[g]),
      .sync    (bus.SYNC),
      .wr      (wr_hit[g]),
      .data    (bus.DIV_DATA),
      .ce      (ce_v[g]),
      .tog     (tog_v[g]),
      .pending (pend_v[g])
    );
  end

  assign clr = bus.SYNC | (|pend_v);

  always_comb begin
    stab_d = stab_q;
    lock_d = lock_q;
    if (clr) begin
      stab_d = '0;
      lock_d = 1'b0;
    end else begin
      if (stab_q != LOCK_MAX) begin
        stab_d = stab_q + LOCK_W'(1);
      end
      lock_d = (stab_d == LOCK_MAX);
    end
  end

  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      stab_q <= '0;
      lock_q <= 1'b0;
    end else begin
      stab_q <= stab_d;
      lock_q <= lock_d;
    end
  end

  assign bus.CE_OUT  = ce_v;
  assign bus.TOG_OUT = tog_v;
  assign bus.PENDING = pend_v;
  assign bus.LOCK    = lock_q;

endmodule
